tlb_unit: RTL and testbench

32-entry fully associative joint TLB that acts as the responder to the CP0 TLB interface. Executes TLBR/TLBWI/TLBWR issued by CP0, supplies the combinational TLBP probe result and the Random register value, and translates virtual addresses for the instruction-fetch and data-memory stages. Lookup results are registered and feed the exception control unit as refill, invalid and modified faults.

---
 rtl/tlb_unit.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_tlb_unit.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_unit.sv
// ---------------------------------------------------------------------------
// tlb_unit
// 32-entry fully associative joint TLB serving as the responder for the CP0
// TLB interface. It executes TLBR/TLBWI/TLBWR, supplies the combinational
// TLBP probe result and the Random register, and translates virtual
// addresses for the fetch (i_) and data (d_) stages with registered results.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   stall               freezes entry writes, Random and lookup registers
//   tlbOp               00 none, 01 TLBR, 10 TLBWI, 11 TLBWR
//   regIndex            CP0 Index; [4:0] selects entry for TLBR/TLBWI
//   regEntryHi/Lo0/Lo1/PageMask  write data and probe key (EntryHi[7:0]=ASID)
//   regWired, regWiredWrite      CP0 Wired value and its write strobe
//   regIndexIn          probe result {~hit, 26'h0, hitIdx} (combinational)
//   regEntryHiIn/Lo0In/Lo1In/PageMaskIn  entry[regIndex[4:0]] (combinational)
//   regRandomIn         Random register
//   x_req/x_write/x_vaddr        lookup request, store flag, virtual address
//   x_paddr/x_cached/x_miss/x_invalid/x_modified  registered lookup result
// ---------------------------------------------------------------------------
module tlb_unit #(
    parameter int ENTRIES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [1:0]  tlbOp,
    input  logic [31:0] regIndex,
    input  logic [31:0] regEntryHi,
    input  logic [31:0] regEntryLo0,
    input  logic [31:0] regEntryLo1,
    input  logic [31:0] regPageMask,
    input  logic [4:0]  regWired,
    input  logic        regWiredWrite,
    output logic [31:0] regIndexIn,
    output logic [31:0] regEntryHiIn,
    output logic [31:0] regEntryLo0In,
    output logic [31:0] regEntryLo1In,
    output logic [31:0] regPageMaskIn,
    output logic [4:0]  regRandomIn,
    input  logic        i_req,
    input  logic        i_write,
    input  logic [31:0] i_vaddr,
    output logic [31:0] i_paddr,
    output logic        i_cached,
    output logic        i_miss,
    output logic        i_invalid,
    output logic        i_modified,
    input  logic        d_req,
    input  logic        d_write,
    input  logic [31:0] d_vaddr,
    output logic [31:0] d_paddr,
    output logic        d_cached,
    output logic        d_miss,
    output logic        d_invalid,
    output logic        d_modified
);

    typedef struct packed {
        logic       hit;
        logic [4:0] idx;
    } matchRes_t;

    typedef struct packed {
        logic [31:0] paddr;
        logic        cached;
        logic        miss;
        logic        invalid;
        logic        modified;
    } xlate_t;

    // Entry array
    logic [ENTRIES-1:0] used_r;
    logic [ENTRIES-1:0] g_r;
    logic [18:0]        vpn2_r [ENTRIES];
    logic [7:0]         asid_r [ENTRIES];
    logic [15:0]        mask_r [ENTRIES];
    logic [19:0]        pfn0_r [ENTRIES];
    logic [19:0]        pfn1_r [ENTRIES];
    logic [2:0]         c0_r   [ENTRIES];
    logic [2:0]         c1_r   [ENTRIES];
    logic [ENTRIES-1:0] d0_r;
    logic [ENTRIES-1:0] d1_r;
    logic [ENTRIES-1:0] v0_r;
    logic [ENTRIES-1:0] v1_r;

    logic [4:0]  random_r;
    logic        wrEn_s;
    logic [4:0]  wrIdx_s;
    logic [15:0] wrMask_s;
    matchRes_t   probe_s;
    xlate_t      iRes_s;
    xlate_t      dRes_s;
    logic [4:0]  rdIdx_s;
    logic        unusedBits_s;

    function automatic logic [4:0] popCount16(input logic [15:0] m);
        logic [4:0] cnt;
        cnt = 5'd0;
        for (int b = 0; b < 16; b++) begin
            cnt = cnt + {4'd0, m[b]};
        end
        return cnt;
    endfunction

    function automatic logic entryMatch(input logic [4:0] e, input logic [18:0] vpn,
                                        input logic [7:0] asid);
        logic [18:0] keep;
        keep = ~{3'b000, mask_r[e]};
        return used_r[e] & ((vpn2_r[e] & keep) == (vpn & keep)) &
               (g_r[e] | (asid_r[e] == asid));
    endfunction

    // Scanning downward lets the lowest matching index overwrite the others.
    function automatic matchRes_t findMatch(input logic [18:0] vpn, input logic [7:0] asid);
        matchRes_t r;
        r = '{hit: 1'b0, idx: 5'd0};
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            r = entryMatch(5'(i), vpn, asid) ? '{hit: 1'b1, idx: 5'(i)} : r;
        end
        return r;
    endfunction

    function automatic xlate_t translate(input logic [31:0] va, input logic isWrite,
                                         input logic [7:0] asid);
        xlate_t      r;
        matchRes_t   m;
        logic [4:0]  n;
        logic        odd;
        logic [31:0] offMask;
        logic [19:0] pfn;
        logic [2:0]  c;
        logic        d;
        logic        v;
        r       = '0;
        m       = findMatch(va[31:13], asid);
        n       = popCount16(mask_r[m.idx]);
        // The page-size mask is contiguous from bit 13, so the even/odd
        // select sits just above the combined page offset.
        odd     = va[5'd12 + n];
        offMask = {3'b000, mask_r[m.idx], 13'h1fff} >> 1;
        pfn     = odd ? pfn1_r[m.idx] : pfn0_r[m.idx];
        c       = odd ? c1_r[m.idx]   : c0_r[m.idx];
        d       = odd ? d1_r[m.idx]   : d0_r[m.idx];
        v       = odd ? v1_r[m.idx]   : v0_r[m.idx];
        if (va[31:30] == 2'b10) begin
            r.paddr  = {3'b000, va[28:0]};
            r.cached = ~va[29];
        end else if (!m.hit) begin
            r.miss = 1'b1;
        end else if (!v) begin
            r.invalid = 1'b1;
        end else begin
            r.paddr    = ({pfn, 12'h000} & ~offMask) | (va & offMask);
            r.cached   = (c == 3'd3);
            r.modified = isWrite & ~d;
        end
        return r;
    endfunction

    // Decode the CP0 write command and pick the target entry.
    always_comb begin
        wrEn_s  = 1'b0;
        wrIdx_s = regIndex[4:0];
        case (tlbOp)
            2'b10: begin
                wrEn_s  = ~stall & ~rst;
                wrIdx_s = regIndex[4:0];
            end
            2'b11: begin
                wrEn_s  = ~stall & ~rst;
                wrIdx_s = random_r;
            end
            default: begin
                wrEn_s  = 1'b0;
                wrIdx_s = regIndex[4:0];
            end
        endcase
    end

    assign wrMask_s = regPageMask[28:13];

    // Valid bits: cleared by reset, set by any TLB write.
    always_ff @(posedge clk) begin
        if (rst) begin
            used_r <= '0;
        end else if (wrEn_s) begin
            used_r[wrIdx_s] <= 1'b1;
        end
    end

    // Entry payload; only meaningful while the entry is used.
    always_ff @(posedge clk) begin
        if (wrEn_s) begin
            vpn2_r[wrIdx_s] <= regEntryHi[31:13] & ~{3'b000, wrMask_s};
            asid_r[wrIdx_s] <= regEntryHi[7:0];
            mask_r[wrIdx_s] <= wrMask_s;
            g_r[wrIdx_s]    <= regEntryLo0[0] & regEntryLo1[0];
            pfn0_r[wrIdx_s] <= regEntryLo0[25:6];
            c0_r[wrIdx_s]   <= regEntryLo0[5:3];
            d0_r[wrIdx_s]   <= regEntryLo0[2];
            v0_r[wrIdx_s]   <= regEntryLo0[1];
            pfn1_r[wrIdx_s] <= regEntryLo1[25:6];
            c1_r[wrIdx_s]   <= regEntryLo1[5:3];
            d1_r[wrIdx_s]   <= regEntryLo1[2];
            v1_r[wrIdx_s]   <= regEntryLo1[1];
        end
    end

    // Random counts down towards Wired and wraps to 31.
    always_ff @(posedge clk) begin
        if (rst) begin
            random_r <= 5'd31;
        end else if (!stall) begin
            if (regWiredWrite || (random_r <= regWired)) begin
                random_r <= 5'd31;
            end else begin
                random_r <= random_r - 5'd1;
            end
        end
    end

    assign regRandomIn = random_r;

    // Probe and both lookup translations against current entry state.
    always_comb begin
        probe_s = findMatch(regEntryHi[31:13], regEntryHi[7:0]);
        iRes_s  = translate(i_vaddr, i_write, regEntryHi[7:0]);
        dRes_s  = translate(d_vaddr, d_write, regEntryHi[7:0]);
    end

    assign regIndexIn = {~probe_s.hit, 26'h0, probe_s.idx};
    assign rdIdx_s    = regIndex[4:0];

    // TLBR read-out; unused entries read as zero.
    always_comb begin
        regEntryHiIn  = 32'h0;
        regEntryLo0In = 32'h0;
        regEntryLo1In = 32'h0;
        regPageMaskIn = 32'h0;
        if (used_r[rdIdx_s]) begin
            regEntryHiIn  = {vpn2_r[rdIdx_s], 5'h00, asid_r[rdIdx_s]};
            regEntryLo0In = {6'h00, pfn0_r[rdIdx_s], c0_r[rdIdx_s], d0_r[rdIdx_s],
                             v0_r[rdIdx_s], g_r[rdIdx_s]};
            regEntryLo1In = {6'h00, pfn1_r[rdIdx_s], c1_r[rdIdx_s], d1_r[rdIdx_s],
                             v1_r[rdIdx_s], g_r[rdIdx_s]};
            regPageMaskIn = {3'h0, mask_r[rdIdx_s], 13'h0000};
        end else begin
            regEntryHiIn  = 32'h0;
            regEntryLo0In = 32'h0;
            regEntryLo1In = 32'h0;
            regPageMaskIn = 32'h0;
        end
    end

    // Registered lookup results; fault flags qualified by the request.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_paddr    <= 32'h0;
            i_cached   <= 1'b0;
            i_miss     <= 1'b0;
            i_invalid  <= 1'b0;
            i_modified <= 1'b0;
            d_paddr    <= 32'h0;
            d_cached   <= 1'b0;
            d_miss     <= 1'b0;
            d_invalid  <= 1'b0;
            d_modified <= 1'b0;
        end else if (!stall) begin
            i_paddr    <= iRes_s.paddr;
            i_cached   <= iRes_s.cached;
            i_miss     <= i_req & iRes_s.miss;
            i_invalid  <= i_req & iRes_s.invalid;
            i_modified <= i_req & iRes_s.modified;
            d_paddr    <= dRes_s.paddr;
            d_cached   <= dRes_s.cached;
            d_miss     <= d_req & dRes_s.miss;
            d_invalid  <= d_req & dRes_s.invalid;
            d_modified <= d_req & dRes_s.modified;
        end
    end

    // CP0 register bits that carry no TLB state.
    assign unusedBits_s = ^{regIndex[31:5], regEntryHi[12:8], regEntryLo0[31:26],
                            regEntryLo1[31:26], regPageMask[31:29], regPageMask[12:0]};

endmodule

// File: tb/tb_tlb_unit.sv
module tb_tlb_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [1:0]  tlbOp;
    logic [31:0] regIndex;
    logic [31:0] regEntryHi;
    logic [31:0] regEntryLo0;
    logic [31:0] regEntryLo1;
    logic [31:0] regPageMask;
    logic [4:0]  regWired;
    logic        regWiredWrite;
    logic [31:0] regIndexIn;
    logic [31:0] regEntryHiIn;
    logic [31:0] regEntryLo0In;
    logic [31:0] regEntryLo1In;
    logic [31:0] regPageMaskIn;
    logic [4:0]  regRandomIn;
    logic        i_req;
    logic        i_write;
    logic [31:0] i_vaddr;
    logic [31:0] i_paddr;
    logic        i_cached;
    logic        i_miss;
    logic        i_invalid;
    logic        i_modified;
    logic        d_req;
    logic        d_write;
    logic [31:0] d_vaddr;
    logic [31:0] d_paddr;
    logic        d_cached;
    logic        d_miss;
    logic        d_invalid;
    logic        d_modified;

    tlb_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .tlbOp(tlbOp),
        .regIndex(regIndex), .regEntryHi(regEntryHi),
        .regEntryLo0(regEntryLo0), .regEntryLo1(regEntryLo1),
        .regPageMask(regPageMask), .regWired(regWired),
        .regWiredWrite(regWiredWrite), .regIndexIn(regIndexIn),
        .regEntryHiIn(regEntryHiIn), .regEntryLo0In(regEntryLo0In),
        .regEntryLo1In(regEntryLo1In), .regPageMaskIn(regPageMaskIn),
        .regRandomIn(regRandomIn),
        .i_req(i_req), .i_write(i_write), .i_vaddr(i_vaddr), .i_paddr(i_paddr),
        .i_cached(i_cached), .i_miss(i_miss), .i_invalid(i_invalid),
        .i_modified(i_modified),
        .d_req(d_req), .d_write(d_write), .d_vaddr(d_vaddr), .d_paddr(d_paddr),
        .d_cached(d_cached), .d_miss(d_miss), .d_invalid(d_invalid),
        .d_modified(d_modified)
    );

    typedef struct {
        int          id;
        logic [31:0] pa;
        logic        ca;
        logic        mi;
        logic        inv;
        logic        mo;
        logic        chkA;
    } exp_t;

    exp_t dQ[$];
    exp_t iQ[$];
    exp_t eD;
    exp_t eI;
    int   tests = 0;
    int   fails = 0;
    logic dPend = 1'b0;
    logic iPend = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Note which cycles carry a lookup whose result appears one cycle later.
    always @(posedge clk) begin
        dPend <= d_req && !stall && !rst;
        iPend <= i_req && !stall && !rst;
    end

    // Monitor: pop and compare when a registered result is presented.
    always @(negedge clk) begin
        if (dPend) begin
            if (dQ.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL d_unexpected: got a result expected none");
            end else begin
                eD = dQ.pop_front();
                chk($sformatf("d%0d_flags", eD.id), {29'h0, d_miss, d_invalid, d_modified},
                    {29'h0, eD.mi, eD.inv, eD.mo});
                if (eD.chkA) begin
                    chk($sformatf("d%0d_paddr", eD.id), d_paddr, eD.pa);
                    chk($sformatf("d%0d_cached", eD.id), {31'h0, d_cached}, {31'h0, eD.ca});
                end
            end
        end
        if (iPend) begin
            if (iQ.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL i_unexpected: got a result expected none");
            end else begin
                eI = iQ.pop_front();
                chk($sformatf("i%0d_flags", eI.id), {29'h0, i_miss, i_invalid, i_modified},
                    {29'h0, eI.mi, eI.inv, eI.mo});
                if (eI.chkA) begin
                    chk($sformatf("i%0d_paddr", eI.id), i_paddr, eI.pa);
                    chk($sformatf("i%0d_cached", eI.id), {31'h0, i_cached}, {31'h0, eI.ca});
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic dLook(input int id, input logic [31:0] va, input logic wr,
                         input logic [31:0] pa, input logic ca, input logic mi,
                         input logic inv, input logic mo, input logic chkA);
        d_vaddr = va;
        d_write = wr;
        d_req   = 1'b1;
        dQ.push_back('{id, pa, ca, mi, inv, mo, chkA});
        tick();
        d_req   = 1'b0;
        d_write = 1'b0;
    endtask

    task automatic iLook(input int id, input logic [31:0] va, input logic [31:0] pa,
                         input logic ca, input logic mi, input logic inv, input logic chkA);
        i_vaddr = va;
        i_req   = 1'b1;
        iQ.push_back('{id, pa, ca, mi, inv, 1'b0, chkA});
        tick();
        i_req   = 1'b0;
    endtask

    task automatic tlbWrite(input logic [1:0] op, input logic [31:0] idx, input logic [31:0] hi,
                            input logic [31:0] lo0, input logic [31:0] lo1, input logic [31:0] pm);
        regIndex    = idx;
        regEntryHi  = hi;
        regEntryLo0 = lo0;
        regEntryLo1 = lo1;
        regPageMask = pm;
        tlbOp       = op;
        tick();
        tlbOp       = 2'b00;
    endtask

    task automatic readChk(input logic [31:0] idx, input logic [31:0] hi, input logic [31:0] lo0,
                           input logic [31:0] lo1, input logic [31:0] pm);
        regIndex = idx;
        #1;
        chk($sformatf("tlbr%0d_hi", idx), regEntryHiIn, hi);
        chk($sformatf("tlbr%0d_lo0", idx), regEntryLo0In, lo0);
        chk($sformatf("tlbr%0d_lo1", idx), regEntryLo1In, lo1);
        chk($sformatf("tlbr%0d_pm", idx), regPageMaskIn, pm);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0] ev;
        logic [4:0] wiredSeq [6];
        rst = 1'b1; stall = 1'b0; tlbOp = 2'b00; regIndex = 32'h0;
        regEntryHi = 32'h0; regEntryLo0 = 32'h0; regEntryLo1 = 32'h0; regPageMask = 32'h0;
        regWired = 5'd0; regWiredWrite = 1'b0;
        i_req = 1'b0; i_write = 1'b0; i_vaddr = 32'h0;
        d_req = 1'b0; d_write = 1'b0; d_vaddr = 32'h0;
        repeat (3) tick();

        // Reset state
        chk("rst_probe", regIndexIn, 32'h80000000);
        chk("rst_random", {27'h0, regRandomIn}, 32'd31);
        chk("rst_dpaddr", d_paddr, 32'h0);
        chk("rst_dflags", {28'h0, d_cached, d_miss, d_invalid, d_modified}, 32'h0);
        chk("rst_ipaddr", i_paddr, 32'h0);
        chk("rst_tlbr_hi", regEntryHiIn, 32'h0);
        rst = 1'b0;

        // Random with Wired=0: 31 down to 0 then wraps
        for (int k = 0; k < 40; k++) begin
            ev = 5'(31 - k);
            chk($sformatf("random_w0_%0d", k), {27'h0, regRandomIn}, {27'h0, ev});
            tick();
        end
        // Current value is 23 (<= 28), so Wired=28 forces 31 next
        regWired = 5'd28;
        wiredSeq = '{5'd31, 5'd30, 5'd29, 5'd28, 5'd31, 5'd30};
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("random_w28_%0d", k), {27'h0, regRandomIn}, {27'h0, wiredSeq[k]});
        end
        regWired = 5'd0;
        regWiredWrite = 1'b1;
        tick();
        chk("random_wiredwrite", {27'h0, regRandomIn}, 32'd31);
        regWiredWrite = 1'b0;
        tick();
        chk("random_after_ww", {27'h0, regRandomIn}, 32'd30);
        stall = 1'b1;
        tick();
        chk("random_stall1", {27'h0, regRandomIn}, 32'd30);
        tick();
        chk("random_stall2", {27'h0, regRandomIn}, 32'd30);
        stall = 1'b0;
        tick();
        chk("random_unstall", {27'h0, regRandomIn}, 32'd29);

        // TLBWI index 5: VPN2 0x201 ASID 1, even PFN 0x100 C3 D1 V1, odd V0
        tlbWrite(2'b10, 32'd5, 32'h00402001, 32'h0000401E, 32'h00008010, 32'h0);
        readChk(32'd5, 32'h00402001, 32'h0000401E, 32'h00008010, 32'h0);
        chk("probe_hit5", regIndexIn, 32'h00000005);
        dLook(1, 32'h00402ABC, 1'b0, 32'h00100ABC, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        dLook(2, 32'h00403000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        iLook(3, 32'h00402ABC, 32'h00100ABC, 1'b1, 1'b0, 1'b0, 1'b1);

        // ASID 2 does not match a non-global entry
        regEntryHi = 32'h00402002;
        #1;
        chk("probe_asid2_miss", regIndexIn, 32'h80000000);
        dLook(4, 32'h00402ABC, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Rewrite as global: any ASID hits
        tlbWrite(2'b10, 32'd5, 32'h00402001, 32'h0000401F, 32'h00008011, 32'h0);
        regEntryHi = 32'h00402002;
        #1;
        chk("probe_global_hit", regIndexIn, 32'h00000005);
        readChk(32'd5, 32'h00402001, 32'h0000401F, 32'h00008011, 32'h0);
        dLook(5, 32'h00402ABC, 1'b0, 32'h00100ABC, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        // Index 6: even PFN 0x123 C2 D0 V1, odd PFN 0x124 C3 D1 V1
        tlbWrite(2'b10, 32'd6, 32'h00600001, 32'h000048D2, 32'h0000491E, 32'h0);
        dLook(6, 32'h00600010, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        dLook(7, 32'h00600010, 1'b0, 32'h00123010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        dLook(8, 32'h00601020, 1'b1, 32'h00124020, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        // Unmapped segments and a miss
        dLook(9, 32'h80001234, 1'b0, 32'h00001234, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        dLook(10, 32'hA0001234, 1'b1, 32'h00001234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        dLook(11, 32'h12345000, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Lookup in the same cycle as a write sees the old contents
        regIndex = 32'd7; regEntryHi = 32'h70000001;
        regEntryLo0 = 32'h0001555E; regEntryLo1 = 32'h0; regPageMask = 32'h0;
        tlbOp = 2'b10;
        dLook(12, 32'h70000100, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tlbOp = 2'b00;
        dLook(13, 32'h70000100, 1'b0, 32'h00555100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        // 16K page via TLBWR at Random=17
        regEntryHi = 32'h0123E003; regEntryLo0 = 32'h0001001E;
        regEntryLo1 = 32'h0002001E; regPageMask = 32'h00006000;
        for (int w = 0; w < 64 && regRandomIn != 5'd17; w++) tick();
        chk("random_at_17", {27'h0, regRandomIn}, 32'd17);
        tlbOp = 2'b11;
        tick();
        tlbOp = 2'b00;
        readChk(32'd17, 32'h01238003, 32'h0001001E, 32'h0002001E, 32'h00006000);
        chk("probe_16k", regIndexIn, 32'h00000011);
        dLook(14, 32'h01239ABC, 1'b0, 32'h00401ABC, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        dLook(15, 32'h0123DABC, 1'b1, 32'h00801ABC, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset overrides a write in the same cycle
        regIndex = 32'd8; regEntryHi = 32'h00402001;
        regEntryLo0 = 32'h0000401E; regEntryLo1 = 32'h0; regPageMask = 32'h0;
        tlbOp = 2'b10;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tlbOp = 2'b00;
        readChk(32'd8, 32'h0, 32'h0, 32'h0, 32'h0);
        readChk(32'd5, 32'h0, 32'h0, 32'h0, 32'h0);
        chk("rst2_probe", regIndexIn, 32'h80000000);
        chk("rst2_random", {27'h0, regRandomIn}, 32'd31);
        chk("rst2_dpaddr", d_paddr, 32'h0);

        repeat (2) tick();
        chk("dq_drained", dQ.size(), 32'd0);
        chk("iq_drained", iQ.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
